// File: rtl/id_issue_ctrl_if.sv
// Decode-to-ID/EX control bundle between the ID stage and the issue controller.
// Carries decoded fields in, packed control word, enables and counters out.
interface id_issue_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             dec_valid;
  logic             dec_memtoreg;
  logic             dec_branch;
  logic             dec_memwrite;
  logic             dec_memread;
  logic             dec_alusrc;
  logic             dec_regwrite;
  logic [3:0]       dec_alu_control;
  logic [4:0]       dec_rs1;
  logic [4:0]       dec_rs2;
  logic [4:0]       dec_rd;
  logic             dec_uses_rs2;
  logic             ex_taken;
  logic [10:0]      control;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output dec_valid, dec_memtoreg, dec_branch, dec_memwrite,
    output dec_memread, dec_alusrc, dec_regwrite, dec_alu_control,
    output dec_rs1, dec_rs2, dec_rd, dec_uses_rs2, ex_taken,
    input  control, pc_write, if_id_write, if_id_flush,
    input  stall_count, flush_count
  );

  modport slave (
    input  dec_valid, dec_memtoreg, dec_branch, dec_memwrite,
    input  dec_memread, dec_alusrc, dec_regwrite, dec_alu_control,
    input  dec_rs1, dec_rs2, dec_rd, dec_uses_rs2, ex_taken,
    output control, pc_write, if_id_write, if_id_flush,
    output stall_count, flush_count
  );
endinterface

// File: rtl/id_issue_ctrl.sv
// ID/EX control-word producer: bubbles on load-use and taken redirects,
// drives PC / IF-ID enables and keeps saturating stall/flush counters.
module id_issue_ctrl #(
  parameter int LOAD_STALL  = 1,
  parameter int FLUSH_SLOTS = 2,
  parameter int CNT_W       = 16
) (
  input logic          clk,
  input logic          rst,
  id_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [1:0] LD_RELOAD = 2'(LOAD_STALL - 1);
  localparam logic [1:0] FL_RELOAD = 2'(FLUSH_SLOTS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             ld_pend_q;
  logic [4:0]       ld_rd_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic [10:0] issue_w;
  logic [10:0] ctrl;
  logic        hz;
  logic        rs1_hit;
  logic        rs2_hit;
  logic        pc_we;
  logic        ifid_we;
  logic        ifid_fl;
  logic        st_inc;
  logic        fl_inc;

  assign issue_w = bus.dec_valid ?
    {1'b1, bus.dec_regwrite, bus.dec_alu_control,
     bus.dec_alusrc, bus.dec_memread, bus.dec_memwrite,
     bus.dec_branch, bus.dec_memtoreg} : 11'b0;

  assign rs1_hit = bus.dec_rs1 == ld_rd_q;
  assign rs2_hit = bus.dec_uses_rs2 &&
                   (bus.dec_rs2 == ld_rd_q);
  assign hz = bus.dec_valid && ld_pend_q &&
              (ld_rd_q != 5'd0) && (rs1_hit || rs2_hit);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = 11'b0;
    pc_we   = 1'b0;
    ifid_we = 1'b0;
    ifid_fl = 1'b0;
    st_inc  = 1'b0;
    fl_inc  = 1'b0;
    if (rst) begin
      state_d = RUN;
      cnt_d   = 2'd0;
    end else if (bus.ex_taken) begin
      // redirect wins over any pending stall and restarts the flush window
      ifid_fl = 1'b1;
      pc_we   = 1'b1;
      ifid_we = 1'b1;
      fl_inc  = 1'b1;
      if (FLUSH_SLOTS > 1) begin
        state_d = FLUSH;
        cnt_d   = FL_RELOAD;
      end else begin
        state_d = RUN;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (hz) begin
            st_inc = 1'b1;
            if (LOAD_STALL > 1) begin
              state_d = STALL;
              cnt_d   = LD_RELOAD;
            end
          end else begin
            ctrl    = issue_w;
            pc_we   = 1'b1;
            ifid_we = 1'b1;
          end
        end
        STALL: begin
          st_inc = 1'b1;
          cnt_d  = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = RUN;
        end
        FLUSH: begin
          ifid_fl = 1'b1;
          pc_we   = 1'b1;
          ifid_we = 1'b1;
          fl_inc  = 1'b1;
          cnt_d   = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= 2'd0;
      ld_pend_q <= 1'b0;
      ld_rd_q   <= 5'd0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_pend_q <= ctrl[10] & ctrl[3];
      ld_rd_q   <= bus.dec_rd;
      if (st_inc && stall_q != CNT_MAX) stall_q <= stall_q + 1'b1;
      if (fl_inc && flush_q != CNT_MAX) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.control     = ctrl;
  assign bus.pc_write    = pc_we;
  assign bus.if_id_write = ifid_we;
  assign bus.if_id_flush = ifid_fl;
  assign bus.stall_count = stall_q;
  assign bus.flush_count = flush_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl: default instance plus a
// 2-bit-counter, 2-cycle-load-stall instance on the same stimulus.
module tb_id_issue_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  id_issue_ctrl_if #(.CNT_W(16)) bm ();
  id_issue_ctrl_if #(.CNT_W(2))  bs ();

  id_issue_ctrl #(
    .LOAD_STALL(1), .FLUSH_SLOTS(2), .CNT_W(16)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bm)
  );

  id_issue_ctrl #(
    .LOAD_STALL(2), .FLUSH_SLOTS(2), .CNT_W(2)
  ) u_sat (
    .clk(clk), .rst(rst), .bus(bs)
  );

  localparam logic [10:0] C_ADD = 11'b11001010000;
  localparam logic [10:0] C_LW  = 11'b11000011001;
  localparam logic [10:0] C_USE = 11'b11000000000;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic rw,
                     input logic [3:0] alu, input logic src,
                     input logic mr, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [4:0] rd,
                     input logic u2, input logic tk);
    bm.dec_valid = v;       bs.dec_valid = v;
    bm.dec_regwrite = rw;   bs.dec_regwrite = rw;
    bm.dec_alu_control = alu;
    bs.dec_alu_control = alu;
    bm.dec_alusrc = src;    bs.dec_alusrc = src;
    bm.dec_memread = mr;    bs.dec_memread = mr;
    bm.dec_memtoreg = mr;   bs.dec_memtoreg = mr;
    bm.dec_memwrite = 1'b0; bs.dec_memwrite = 1'b0;
    bm.dec_branch = 1'b0;   bs.dec_branch = 1'b0;
    bm.dec_rs1 = rs1;       bs.dec_rs1 = rs1;
    bm.dec_rs2 = rs2;       bs.dec_rs2 = rs2;
    bm.dec_rd = rd;         bs.dec_rd = rd;
    bm.dec_uses_rs2 = u2;   bs.dec_uses_rs2 = u2;
    bm.ex_taken = tk;       bs.ex_taken = tk;
  endtask

  task automatic lw(input logic [4:0] rd);
    drv(1, 1, 4'd0, 1, 1, 5'd1, 5'd0, rd, 0, 0);
  endtask

  task automatic use_(input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u2, input logic tk);
    drv(1, 1, 4'd0, 0, 0, rs1, rs2, 5'd8, u2, tk);
  endtask

  initial begin
    rst = 1'b1;
    drv(1, 1, 4'b0010, 1, 0, 5'd1, 5'd2, 5'd3, 0, 0);
    #1;
    chk("rst_ctrl", 32'(bm.control), 32'd0);
    chk("rst_pc", 32'(bm.pc_write), 32'd0);
    chk("rst_ifid", 32'(bm.if_id_write), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_stall_cnt", 32'(bm.stall_count), 32'd0);
    chk("rst_flush_cnt", 32'(bm.flush_count), 32'd0);

    // plain issue
    #1;
    chk("add_ctrl", 32'(bm.control), 32'(C_ADD));
    chk("add_pc", 32'(bm.pc_write), 32'd1);
    chk("add_ifid", 32'(bm.if_id_write), 32'd1);
    chk("add_flush", 32'(bm.if_id_flush), 32'd0);
    cyc();

    // load-use on rs1
    lw(5'd5); #1;
    chk("lw_ctrl", 32'(bm.control), 32'(C_LW));
    cyc();
    use_(5'd5, 5'd6, 1, 0); #1;
    chk("hz_ctrl", 32'(bm.control), 32'd0);
    chk("hz_pc", 32'(bm.pc_write), 32'd0);
    chk("hz_ifid", 32'(bm.if_id_write), 32'd0);
    cyc();
    chk("hz_stall_cnt", 32'(bm.stall_count), 32'd1);
    chk("sat_stall_cnt1", 32'(bs.stall_count), 32'd1);
    #1;
    chk("after_hz_ctrl", 32'(bm.control), 32'(C_USE));
    chk("after_hz_pc", 32'(bm.pc_write), 32'd1);
    chk("sat_stall2_ctrl", 32'(bs.control), 32'd0);
    chk("sat_stall2_pc", 32'(bs.pc_write), 32'd0);
    cyc();
    chk("hz_stall_cnt_hold", 32'(bm.stall_count), 32'd1);
    chk("sat_stall_cnt2", 32'(bs.stall_count), 32'd2);

    // x0 destination never stalls
    lw(5'd0); cyc();
    use_(5'd0, 5'd0, 1, 0); #1;
    chk("x0_pc", 32'(bm.pc_write), 32'd1);
    chk("x0_ctrl", 32'(bm.control), 32'(C_USE));
    cyc();

    // rs2 gated by dec_uses_rs2
    lw(5'd7); cyc();
    use_(5'd1, 5'd7, 0, 0); #1;
    chk("rs2_off_pc", 32'(bm.pc_write), 32'd1);
    cyc();
    lw(5'd7); cyc();
    use_(5'd1, 5'd7, 1, 0); #1;
    chk("rs2_on_pc", 32'(bm.pc_write), 32'd0);
    chk("rs2_on_ctrl", 32'(bm.control), 32'd0);
    cyc();
    chk("rs2_stall_cnt", 32'(bm.stall_count), 32'd2);

    // taken redirect: two flush bubbles
    use_(5'd1, 5'd2, 0, 1); #1;
    chk("tk_ctrl", 32'(bm.control), 32'd0);
    chk("tk_flush", 32'(bm.if_id_flush), 32'd1);
    chk("tk_pc", 32'(bm.pc_write), 32'd1);
    chk("tk_ifid", 32'(bm.if_id_write), 32'd1);
    cyc();
    chk("tk_flush_cnt1", 32'(bm.flush_count), 32'd1);
    use_(5'd1, 5'd2, 0, 0); #1;
    chk("fl2_ctrl", 32'(bm.control), 32'd0);
    chk("fl2_flush", 32'(bm.if_id_flush), 32'd1);
    chk("fl2_pc", 32'(bm.pc_write), 32'd1);
    cyc();
    chk("tk_flush_cnt2", 32'(bm.flush_count), 32'd2);
    #1;
    chk("post_fl_ctrl", 32'(bm.control), 32'(C_USE));
    chk("post_fl_flush", 32'(bm.if_id_flush), 32'd0);
    cyc();

    // re-taken while flushing reloads the window
    use_(5'd1, 5'd2, 0, 1); cyc();
    #1;
    chk("retk_flush", 32'(bm.if_id_flush), 32'd1);
    cyc();
    chk("retk_flush_cnt", 32'(bm.flush_count), 32'd4);
    use_(5'd1, 5'd2, 0, 0); #1;
    chk("retk_tail_flush", 32'(bm.if_id_flush), 32'd1);
    chk("retk_tail_ctrl", 32'(bm.control), 32'd0);
    cyc();
    chk("retk_tail_cnt", 32'(bm.flush_count), 32'd5);
    #1;
    chk("retk_run_ctrl", 32'(bm.control), 32'(C_USE));
    chk("retk_run_flush", 32'(bm.if_id_flush), 32'd0);
    cyc();

    // redirect beats load-use
    lw(5'd9); cyc();
    use_(5'd9, 5'd0, 0, 1); #1;
    chk("prio_pc", 32'(bm.pc_write), 32'd1);
    chk("prio_flush", 32'(bm.if_id_flush), 32'd1);
    chk("prio_ctrl", 32'(bm.control), 32'd0);
    cyc();
    chk("prio_stall_cnt", 32'(bm.stall_count), 32'd2);
    chk("prio_flush_cnt", 32'(bm.flush_count), 32'd6);
    use_(5'd1, 5'd2, 0, 0); cyc();

    // saturation of the 2-bit counters
    for (int i = 0; i < 3; i++) begin
      lw(5'd5); cyc();
      use_(5'd5, 5'd6, 1, 0); cyc();
      cyc();
    end
    chk("main_stall_cnt", 32'(bm.stall_count), 32'd5);
    chk("main_flush_cnt", 32'(bm.flush_count), 32'd7);
    chk("sat_stall_cnt", 32'(bs.stall_count), 32'd3);
    chk("sat_flush_cnt", 32'(bs.flush_count), 32'd3);

    // reset in the middle of a flush window
    use_(5'd1, 5'd2, 0, 1); cyc();
    use_(5'd1, 5'd2, 0, 0);
    rst = 1'b1; #1;
    chk("midrst_ctrl", 32'(bm.control), 32'd0);
    chk("midrst_pc", 32'(bm.pc_write), 32'd0);
    chk("midrst_flush", 32'(bm.if_id_flush), 32'd0);
    cyc();
    rst = 1'b0;
    drv(1, 1, 4'b0010, 1, 0, 5'd1, 5'd2, 5'd3, 0, 0); #1;
    chk("midrst_run_ctrl", 32'(bm.control), 32'(C_ADD));
    chk("midrst_run_flush", 32'(bm.if_id_flush), 32'd0);
    chk("midrst_flush_cnt", 32'(bm.flush_count), 32'd0);
    chk("midrst_stall_cnt", 32'(bs.stall_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
